// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store requesters:
// arbitrates, issues the access, waits the fixed latency, captures and acks.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 2,
   parameter int ARB_MODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              gnt_d
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   state_t              state_q, state_d;
   logic [3:0]          count_q, count_d;
   logic                grantData_q;
   logic                lastData_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   ifRdata_q;
   logic [DATA_W-1:0]   dRdata_q;
   logic                pickData;
   logic                anyReq;

   assign anyReq = if_req | d_req;

   // On a tie, round-robin hands the grant to whichever port did not win last.
   always_comb begin
      pickData = d_req;
      if (if_req && d_req) begin
         pickData = (ARB_MODE == 0) ? 1'b1 : ~lastData_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= 4'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (anyReq) state_d = ISSUE;
         end
         ISSUE: begin
            count_d = LAT_M1;
            state_d = WAIT;
         end
         WAIT: begin
            if (count_q == 4'd0) state_d = ACK;
            else count_d = count_q - 4'd1;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      mem_en = 1'b0;
      mem_we = 1'b0;
      if_ack = 1'b0;
      d_ack  = 1'b0;
      case (state_q)
         ISSUE: begin
            mem_en = 1'b1;
            mem_we = we_q;
         end
         ACK: begin
            if_ack = ~grantData_q;
            d_ack  = grantData_q;
         end
         default: begin
         end
      endcase
   end

   // Request fields are latched only at grant, so later changes on the inputs are harmless.
   always_ff @(posedge clk) begin
      if (rst) begin
         grantData_q <= 1'b0;
         lastData_q  <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ifRdata_q   <= '0;
         dRdata_q    <= '0;
      end else begin
         if (state_q == IDLE && anyReq) begin
            grantData_q <= pickData;
            addr_q      <= pickData ? d_addr : if_addr;
            we_q        <= pickData & d_we;
            if (pickData) wdata_q <= d_wdata;
         end
         if (state_q == WAIT && count_q == 4'd0 && !we_q) begin
            if (grantData_q) dRdata_q <= mem_rdata;
            else ifRdata_q <= mem_rdata;
         end
         if (state_q == ACK) lastData_q <= grantData_q;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_rdata  = ifRdata_q;
   assign d_rdata   = dRdata_q;
   assign busy      = (state_q != IDLE);
   assign gnt_d     = grantData_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four builds (latency / arbitration variants) against
// a fixed-latency memory model and a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int N = 4;

   function automatic int latOf(int k);
      case (k)
         0, 1:    return 2;
         2:       return 1;
         default: return 15;
      endcase
   endfunction

   function automatic int modeOf(int k);
      return (k == 0 || k == 2) ? 1 : 0;
   endfunction

   function automatic logic [31:0] initWord(int k, int i);
      return (32'(i) * 32'h9E37_79B1) ^ (32'(k) << 28) ^ 32'h0F0F_0000;
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic        ifReq [N];
   logic        dReq [N];
   logic        dWe [N];
   logic [31:0] ifAddr [N];
   logic [31:0] dAddr [N];
   logic [31:0] dWdata [N];
   logic [31:0] memRdata [N];
   logic [31:0] ifRdata [N];
   logic [31:0] dRdata [N];
   logic [31:0] memAddr [N];
   logic [31:0] memWdata [N];
   logic        ifAck [N];
   logic        dAck [N];
   logic        memEn [N];
   logic        memWe [N];
   logic        busy [N];
   logic        gntD [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : gInst
      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(latOf(g)), .ARB_MODE(modeOf(g))) dut (
         .clk(clk), .rst(rst),
         .if_req(ifReq[g]), .if_addr(ifAddr[g]), .if_rdata(ifRdata[g]), .if_ack(ifAck[g]),
         .d_req(dReq[g]), .d_we(dWe[g]), .d_addr(dAddr[g]), .d_wdata(dWdata[g]),
         .d_rdata(dRdata[g]), .d_ack(dAck[g]),
         .mem_en(memEn[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]), .mem_wdata(memWdata[g]),
         .mem_rdata(memRdata[g]), .busy(busy[g]), .gnt_d(gntD[g]));
   end

   // Memory model: read data is valid only in the cycle MEM_LAT after the strobe.
   logic [31:0] memArr [N][256];
   int          pend [N];
   logic [7:0]  pAddr [N];
   logic        memClear, preEn;
   int          preK;
   logic [7:0]  preIdx;
   logic [31:0] preVal;

   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (memClear) begin
            pend[k] <= 0;
            pAddr[k] <= 8'd0;
            for (int i = 0; i < 256; i++) memArr[k][i] <= initWord(k, i);
         end else begin
            if (preEn && preK == k) memArr[k][preIdx] <= preVal;
            if (memEn[k] && memWe[k]) memArr[k][memAddr[k][9:2]] <= memWdata[k];
            if (memEn[k] && !memWe[k]) begin
               pend[k]  <= latOf(k);
               pAddr[k] <= memAddr[k][9:2];
            end else if (pend[k] > 0) begin
               pend[k] <= pend[k] - 1;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k < N; k++)
         memRdata[k] = (pend[k] == 1) ? memArr[k][pAddr[k]] : (32'hBAD0_0000 | 32'(k));
   end

   // Reference model at transaction level: grant decision, ack cycle, expected registers.
   logic [31:0] refMem [N][256];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   bit          mInTxn, mW, mWe, mLastD;
   int          mGrantC, mAckC;
   logic [31:0] mA, mRd;
   bit          eBusy, eEn, eWe, eIfAck, eDAck, eGnt;
   logic [31:0] eAddr, eWdata, eIfR, eDR;

   task automatic modelReset();
      mInTxn = 0; mW = 0; mWe = 0; mLastD = 0; mGrantC = 0; mAckC = 0;
      mA = '0; mRd = '0; eAddr = '0; eWdata = '0; eIfR = '0; eDR = '0; eGnt = 0;
   endtask

   task automatic modelDecide(int k);
      bit pick;
      if (rst) begin
         modelReset();
      end else if (!mInTxn && (ifReq[k] || dReq[k])) begin
         if (ifReq[k] && dReq[k]) pick = (modeOf(k) == 0) ? 1'b1 : !mLastD;
         else pick = dReq[k];
         mW = pick;
         mA = pick ? dAddr[k] : ifAddr[k];
         mWe = pick && dWe[k];
         if (pick) eWdata = dWdata[k];
         eAddr = mA;
         eGnt = pick;
         mGrantC = cyc;
         mAckC = cyc + latOf(k) + 2;
         mInTxn = 1;
         if (mWe) refMem[k][mA[9:2]] = dWdata[k];
         else mRd = refMem[k][mA[9:2]];
      end
   endtask

   task automatic modelObserve();
      if (mInTxn && cyc > mAckC) mInTxn = 0;
      eBusy  = mInTxn;
      eEn    = mInTxn && cyc == mGrantC + 1;
      eWe    = eEn && mWe;
      eIfAck = mInTxn && cyc == mAckC && !mW;
      eDAck  = mInTxn && cyc == mAckC && mW;
      if (mInTxn && cyc == mAckC) begin
         if (!mW) eIfR = mRd;
         else if (!mWe) eDR = mRd;
         mLastD = mW;
      end
   endtask

   task automatic step(int k);
      modelDecide(k);
      @(posedge clk);
      #1;
      cyc++;
      modelObserve();
   endtask

   task automatic clearInputs();
      for (int k = 0; k < N; k++) begin
         ifReq[k] = 0; dReq[k] = 0; dWe[k] = 0;
         ifAddr[k] = '0; dAddr[k] = '0; dWdata[k] = '0;
      end
   endtask

   task automatic doReset(int k);
      clearInputs();
      rst = 1'b1;
      step(k);
      rst = 1'b0;
   endtask

   task automatic preload(int k, logic [7:0] idx, logic [31:0] val);
      refMem[k][idx] = val;
      preK = k; preIdx = idx; preVal = val; preEn = 1'b1;
      step(k);
      preEn = 1'b0;
   endtask

   task automatic applyStimulus(int k);
      ifReq[k]  = ($urandom_range(3) != 0);
      dReq[k]   = ($urandom_range(3) != 0);
      dWe[k]    = ($urandom_range(2) == 0);
      ifAddr[k] = $urandom & 32'hFFFF_F03C;
      dAddr[k]  = $urandom & 32'hFFFF_F03C;
      dWdata[k] = $urandom;
   endtask

   task automatic test_reset();
      doReset(0);
      for (int k = 0; k < N; k++) begin
         vectors++;
         if ({ifAck[k], dAck[k], memEn[k], memWe[k], busy[k], gntD[k], ifRdata[k], dRdata[k],
              memAddr[k], memWdata[k]} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_state inst%0d: got ctl=%b%b%b%b%b%b ifr=%h dr=%h addr=%h wd=%h want all 0",
                     k, ifAck[k], dAck[k], memEn[k], memWe[k], busy[k], gntD[k], ifRdata[k], dRdata[k],
                     memAddr[k], memWdata[k]);
         end
      end
   endtask

   task automatic test_single_fetch();
      int c0;
      doReset(0);
      preload(0, 8'h10, 32'h3C01_1234);
      c0 = cyc;
      ifReq[0] = 1; ifAddr[0] = 32'h0000_0040;
      for (int i = 1; i <= 6; i++) begin
         step(0);
         if (i == 4) ifReq[0] = 0;
         vectors++;
         if (memEn[0] !== (i == 1)) begin
            miscompares++; $display("[TB] FAIL fetch_mem_en c%0d: got %b want %b", cyc - c0, memEn[0], i == 1);
         end
         vectors++;
         if (ifAck[0] !== (i == 4) || dAck[0] !== 1'b0) begin
            miscompares++; $display("[TB] FAIL fetch_ack c%0d: got if=%b d=%b want if=%b d=0", cyc - c0, ifAck[0], dAck[0], i == 4);
         end
         if (i == 1) begin
            vectors++;
            if (memWe[0] !== 1'b0 || memAddr[0] !== 32'h40) begin
               miscompares++; $display("[TB] FAIL fetch_issue: got we=%b addr=%h want we=0 addr=40", memWe[0], memAddr[0]);
            end
         end
         if (i == 4) begin
            vectors++;
            if (ifRdata[0] !== 32'h3C01_1234) begin
               miscompares++; $display("[TB] FAIL fetch_rdata: got %h want 3c011234", ifRdata[0]);
            end
         end
      end
   endtask

   task automatic test_store();
      logic [31:0] loadVal;
      int c0;
      doReset(0);
      loadVal = refMem[0][8'h40];
      c0 = cyc;
      dReq[0] = 1; dWe[0] = 0; dAddr[0] = 32'h100;
      for (int i = 1; i <= 15; i++) begin
         step(0);
         if (i == 4 || i == 14) begin
            vectors++;
            if (dAck[0] !== 1'b1 || dRdata[0] !== ((i == 4) ? loadVal : 32'hDEAD_BEEF)) begin
               miscompares++; $display("[TB] FAIL load_ack i%0d: got ack=%b rd=%h want ack=1 rd=%h", i, dAck[0], dRdata[0], (i == 4) ? loadVal : 32'hDEAD_BEEF);
            end
            dReq[0] = 0;
         end
         if (i == 5) begin
            dReq[0] = 1; dWe[0] = 1; dAddr[0] = 32'h100; dWdata[0] = 32'hDEAD_BEEF;
         end
         if (i == 6 || i == 7) begin
            vectors++;
            if ({memEn[0], memWe[0]} !== ((i == 6) ? 2'b11 : 2'b00)) begin
               miscompares++; $display("[TB] FAIL store_strobe i%0d: got en/we=%b%b want %b", i, memEn[0], memWe[0], (i == 6) ? 2'b11 : 2'b00);
            end
         end
         if (i == 6) begin
            vectors++;
            if (memAddr[0] !== 32'h100 || memWdata[0] !== 32'hDEAD_BEEF) begin
               miscompares++; $display("[TB] FAIL store_bus: got addr=%h wd=%h want 100/deadbeef", memAddr[0], memWdata[0]);
            end
         end
         if (i == 9) begin
            vectors++;
            if (dAck[0] !== 1'b1) begin
               miscompares++; $display("[TB] FAIL store_ack: got %b want 1", dAck[0]);
            end
            dReq[0] = 0; dWe[0] = 0;
         end
         if (i == 10) begin
            dReq[0] = 1; dWe[0] = 0; dAddr[0] = 32'h100;
         end
         if (i >= 5 && i < 14) begin
            vectors++;
            if (dRdata[0] !== loadVal) begin
               miscompares++; $display("[TB] FAIL store_keeps_rdata i%0d: got %h want %h", i, dRdata[0], loadVal);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      int c0;
      doReset(0);
      c0 = cyc;
      ifReq[0] = 1; ifAddr[0] = 32'h8; dReq[0] = 1; dWe[0] = 0; dAddr[0] = 32'h200;
      for (int i = 1; i <= 20; i++) begin
         step(0);
         vectors++;
         if (dAck[0] !== (i == 4 || i == 14) || ifAck[0] !== (i == 9 || i == 19)) begin
            miscompares++; $display("[TB] FAIL rr_order i%0d: got if=%b d=%b want if=%b d=%b", i, ifAck[0], dAck[0], i == 9 || i == 19, i == 4 || i == 14);
         end
         if (i == 4 || i == 9) begin
            vectors++;
            if (dRdata[0] !== refMem[0][8'h80] || ifRdata[0] !== ((i == 9) ? refMem[0][8'h02] : 32'h0)) begin
               miscompares++; $display("[TB] FAIL rr_rdata i%0d: got if=%h d=%h want if=%h d=%h", i, ifRdata[0], dRdata[0], (i == 9) ? refMem[0][8'h02] : 32'h0, refMem[0][8'h80]);
            end
         end
         if (i == 19) begin
            ifReq[0] = 0; dReq[0] = 0;
         end
      end
   endtask

   task automatic test_fixed_priority();
      doReset(1);
      ifReq[1] = 1; ifAddr[1] = 32'h10; dReq[1] = 1; dWe[1] = 0; dAddr[1] = 32'h20;
      for (int i = 1; i <= 20; i++) begin
         step(1);
         vectors++;
         if (dAck[1] !== (i == 4 || i == 9 || i == 14) || ifAck[1] !== (i == 19)) begin
            miscompares++; $display("[TB] FAIL fixed_prio i%0d: got if=%b d=%b want if=%b d=%b", i, ifAck[1], dAck[1], i == 19, i == 4 || i == 9 || i == 14);
         end
         if (i == 14) dReq[1] = 0;
         if (i == 19) ifReq[1] = 0;
      end
   endtask

   task automatic test_reset_mid_wait();
      doReset(0);
      dReq[0] = 1; dWe[0] = 0; dAddr[0] = 32'h40;
      for (int i = 1; i <= 18; i++) begin
         step(0);
         if (i == 4) begin
            vectors++;
            if (dRdata[0] !== refMem[0][8'h10]) begin
               miscompares++; $display("[TB] FAIL prior_load: got %h want %h", dRdata[0], refMem[0][8'h10]);
            end
            dReq[0] = 0;
         end
         if (i == 5) begin dReq[0] = 1; dAddr[0] = 32'h44; end
         if (i == 6) dReq[0] = 0;
         if (i == 8) rst = 1'b1;
         if (i == 9) begin
            rst = 1'b0;
            vectors++;
            if ({ifAck[0], dAck[0], memEn[0], memWe[0], busy[0], gntD[0], ifRdata[0], dRdata[0],
                 memAddr[0], memWdata[0]} !== '0) begin
               miscompares++; $display("[TB] FAIL mid_reset_clear: got busy=%b gnt=%b dr=%h addr=%h want all 0", busy[0], gntD[0], dRdata[0], memAddr[0]);
            end
         end
         if (i == 11) begin ifReq[0] = 1; ifAddr[0] = 32'h80; end
         if (i >= 9) begin
            vectors++;
            if (dAck[0] !== 1'b0 || ifAck[0] !== (i == 15)) begin
               miscompares++; $display("[TB] FAIL mid_reset_ack i%0d: got if=%b d=%b want if=%b d=0", i, ifAck[0], dAck[0], i == 15);
            end
         end
         if (i == 15) begin
            vectors++;
            if (ifRdata[0] !== refMem[0][8'h20]) begin
               miscompares++; $display("[TB] FAIL post_reset_fetch: got %h want %h", ifRdata[0], refMem[0][8'h20]);
            end
            ifReq[0] = 0;
         end
      end
   endtask

   task automatic test_latency(int k);
      int L;
      logic [31:0] addr, want;
      L = latOf(k);
      doReset(k);
      addr = $urandom & 32'hFFFF_F03C;
      want = refMem[k][addr[9:2]];
      dReq[k] = 1; dWe[k] = 0; dAddr[k] = addr;
      for (int i = 1; i <= L + 4; i++) begin
         step(k);
         if (i == 1) dReq[k] = 0;
         vectors++;
         if (dAck[k] !== (i == L + 2) || busy[k] !== (i <= L + 2)) begin
            miscompares++; $display("[TB] FAIL latency%0d i%0d: got ack=%b busy=%b want ack=%b busy=%b", L, i, dAck[k], busy[k], i == L + 2, i <= L + 2);
         end
         if (i == L + 2) begin
            vectors++;
            if (dRdata[k] !== want) begin
               miscompares++; $display("[TB] FAIL latency%0d_rdata: got %h want %h", L, dRdata[k], want);
            end
         end
      end
   endtask

   task automatic test_random(int k, int n);
      doReset(k);
      for (int i = 0; i < n; i++) begin
         applyStimulus(k);
         step(k);
         vectors++;
         if ({ifAck[k], dAck[k], memEn[k], memWe[k], busy[k], gntD[k]} !== {eIfAck, eDAck, eEn, eWe, eBusy, eGnt}) begin
            miscompares++; $display("[TB] FAIL rand%0d_ctl cyc%0d: got %b%b%b%b%b%b want %b%b%b%b%b%b", k, cyc,
                                    ifAck[k], dAck[k], memEn[k], memWe[k], busy[k], gntD[k], eIfAck, eDAck, eEn, eWe, eBusy, eGnt);
         end
         vectors++;
         if (memAddr[k] !== eAddr) begin
            miscompares++; $display("[TB] FAIL rand%0d_addr cyc%0d: got %h want %h", k, cyc, memAddr[k], eAddr);
         end
         if (eEn && mW) begin
            vectors++;
            if (memWdata[k] !== eWdata) begin
               miscompares++; $display("[TB] FAIL rand%0d_wdata cyc%0d: got %h want %h", k, cyc, memWdata[k], eWdata);
            end
         end
         vectors++;
         if ({ifRdata[k], dRdata[k]} !== {eIfR, eDR}) begin
            miscompares++; $display("[TB] FAIL rand%0d_rdata cyc%0d: got %h/%h want %h/%h", k, cyc, ifRdata[k], dRdata[k], eIfR, eDR);
         end
      end
      clearInputs();
      for (int i = 0; i < latOf(k) + 4; i++) step(k);
   endtask

   initial begin
      rst = 1'b1; memClear = 1'b1; preEn = 1'b0; preK = 0; preIdx = '0; preVal = '0;
      clearInputs();
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 256; i++) refMem[k][i] = initWord(k, i);
      modelReset();
      step(0);
      memClear = 1'b0;
      test_reset();
      test_single_fetch();
      test_store();
      test_round_robin();
      test_fixed_priority();
      test_reset_mid_wait();
      test_latency(2);
      test_latency(3);
      test_random(0, 300);
      test_random(1, 300);
      test_random(2, 200);
      test_random(3, 300);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between two requesters: the fetch requester (IF stage of the multicycle controller) and the data requester (LW/SW MEM stage).
- Arbitrates between them and sequences each memory access: issue, fixed-latency wait, capture, acknowledge.
- Returns read data to the requester with a one-cycle ack pulse.
- Sits between the multicycle control/datapath and the memory model; it is the only block that drives the memory port.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from the cycle mem_en is high to the cycle mem_rdata is valid; legal range 1..15.
- ARB_MODE, 1, tie-break policy: 0 = fixed priority, data wins; 1 = round-robin.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request, level; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, registered.
- if_ack  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, registered.
- d_ack  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only valid with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.
- gnt_d  out  1  current/last grant owner: 1 = data, 0 = fetch.

Behaviour:
- Reset (synchronous, active-high): every output is 0, state = IDLE, wait counter = 0, last-grant = fetch.
- rst has priority over all other activity in the same cycle.
- State machine (4-bit wait counter):
  - IDLE: in cycle T, if any request is high, pick a winner. Register winner's address; for a data grant also register d_we and d_wdata. Set gnt_d, go to ISSUE. If no request, stay in IDLE.
  - ISSUE (T+1): mem_en = 1; mem_we = d_we for a data grant, else 0. Load counter with MEM_LAT-1, go to WAIT. mem_en and mem_we are high in ISSUE only.
  - WAIT (T+2 .. T+MEM_LAT+1): decrement counter each cycle. In the cycle the counter is 0, mem_rdata is valid. For a read, capture mem_rdata into the granted port's rdata register. Go to ACK.
  - ACK (T+MEM_LAT+2): winner's ack = 1 for exactly this cycle. Update last-grant. Return to IDLE.
- In ACK, requests are never sampled; a requester therefore has one cycle to drop req.
- Latency: req sampled in IDLE at cycle T gives ack at T+MEM_LAT+2.
- Minimum spacing between back-to-back acks is MEM_LAT+3 cycles.
- mem_addr and mem_wdata hold their value from ISSUE until the next grant.
- Stores: same timing as loads; ack pulses; d_rdata is unchanged.
- if_rdata and d_rdata hold their value until the next read ack to that port.
- Both requests high in IDLE:
  - ARB_MODE=0: data always wins.
  - ARB_MODE=1: the port not granted last wins. First tie after reset goes to data.
- Single request: always granted, whatever the mode.
- Request inputs are ignored outside IDLE. Changes to address or data after the grant have no effect.
- Request dropped mid-transaction: the access still completes and ack still pulses.
- Reset mid-transaction: the access is abandoned and no ack is produced. A memory write already strobed in ISSUE is not undone.
- if_ack and d_ack are never high in the same cycle.

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x0000_0040 at cycle 0; memory returns 0x3C01_1234 → mem_en=1, mem_we=0, mem_addr=0x40 at cycle 1; if_ack=1 with if_rdata=0x3C01_1234 at cycle 4 only.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF → mem_en=mem_we=1 for one cycle with those values; d_ack at cycle 4; d_rdata unchanged.
- Round-robin, ARB_MODE=1, both reqs held continuously → grant order data, fetch, data, fetch; acks 5 cycles apart (MEM_LAT=2); acks never coincident.
- Fixed priority, ARB_MODE=0, both held for 3 transactions → three d_acks and zero if_ack; dropping d_req lets fetch win on the next IDLE.
- Reset mid-WAIT: assert rst for 1 cycle at cycle 3 of a load → next cycle all outputs 0, busy=0, no ack ever for that load; a new fetch afterwards completes normally.
- MEM_LAT=1 and MEM_LAT=15 builds: single load ack at T+3 and T+17 respectively; req dropped after ISSUE still yields ack.
